timestamp_mc: RTL and testbench
===============================

# timestamp_mc

Multi-channel timestamp unit that succeeds the single-channel frame timestamp block in the control channel. It runs a free-running nanosecond counter and time-tags edges on CH_NUM asynchronous trigger inputs, each with its own edge selection. Tagged events go through a FWFT FIFO to a ready/valid consumer, such as the U3V format or trigger-log logic. A register-side snapshot port and a counter preset port are retained for the register module.

## Interface
- CLK_PERIOD_NS, 25, counter increment per clk cycle (ns)
- LONG_REG_WD, 64, counter and timestamp width
- CH_NUM, 4, trigger channels (1..8)
- FIFO_DEPTH, 8, event FIFO depth (power of 2, ≥2)
- SYNC_STAGES, 2, synchroniser flops per trigger input (≥2)

- clk  in  1  single clock; all logic in this domain
- reset  in  1  synchronous, active-high
- iv_trig  in  CH_NUM  asynchronous trigger inputs
- iv_edge_mode  in  2*CH_NUM  per channel, bits [2k+1:2k]: 00 off, 01 rise, 10 fall, 11 both
- i_cnt_set  in  1  load counter from iv_cnt_set_val
- iv_cnt_set_val  in  LONG_REG_WD  counter preset value
- i_timestamp_load  in  1  snapshot counter to ov_timestamp_reg
- ov_timestamp_reg  out  LONG_REG_WD  register-side snapshot
- ov_evt_ts  out  LONG_REG_WD  head event timestamp
- ov_evt_ch  out  3  head event channel index
- o_evt_edge  out  1  head event edge: 1 rise, 0 fall
- o_evt_valid  out  1  head event valid
- i_evt_ready  in  1  consumer accepts head event
- ov_fifo_level  out  log2(FIFO_DEPTH)+1  FIFO occupancy
- o_overflow  out  1  sticky event-loss flag
- i_overflow_clr  in  1  clear o_overflow

## Operation
- Counter: priority is reset, then i_cnt_set, then increment.
  - reset: cnt = 0.
  - i_cnt_set: cnt = iv_cnt_set_val.
  - Otherwise cnt = cnt + CLK_PERIOD_NS, modulo 2^LONG_REG_WD (wraps silently).
- Snapshot: when i_timestamp_load = 1, timestamp_reg <= cnt (pre-update value). Otherwise it holds. Reset clears it.
- Per-channel front end:
  - A shift chain of SYNC_STAGES+1 flops.
  - rise = top two bits 01; fall = top two bits 10.
  - The edge is qualified by iv_edge_mode of that cycle.
  - The chains reset to 0. Detection is masked for the first SYNC_STAGES+1 cycles after reset deasserts, so a level that is already high does not produce an event.
- Capture: on a qualified edge, the channel's pending register loads {cnt (current value), edge} and its pending flag is set.
  - If the counter is being set in the same cycle, the old cnt is captured.
  - If a qualified edge arrives while pending = 1 and that pending entry is not granted this cycle, the new event is dropped and o_overflow is set.
- Arbiter: each cycle, if the FIFO is not full (level < FIFO_DEPTH at the start of the cycle), the lowest-index pending channel is written into the FIFO and its pending flag is cleared.
  - If the same channel captures a new edge in the grant cycle, the new capture is loaded and pending stays 1.
  - When the FIFO is full, pending entries wait; they are not dropped.
- FIFO: FWFT with registered head.
  - Pop happens when o_evt_valid & i_evt_ready.
  - Write and pop in the same cycle are allowed; level is unchanged.
- Overflow: set has priority over i_overflow_clr in the same cycle.
- Mode change: takes effect on the next evaluated edge. Pending entries are unaffected.

## Timing
- Reset values: ov_timestamp_reg, ov_evt_ts, ov_evt_ch, o_evt_edge, o_evt_valid, ov_fifo_level and o_overflow are all 0.
- Trigger pin to detection: SYNC_STAGES+1 clk, plus up to 1 clk of sampling uncertainty.
- Pipeline after detection:
  - Detect cycle D: pending loads.
  - D+1: FIFO write (uncontended).
  - D+2: o_evt_valid = 1, with ov_fifo_level = 1 when the FIFO was empty.
- Under contention, channel k waits one extra cycle per lower-index pending channel.
- The event order in the FIFO is capture order. Same-cycle captures are ordered by ascending channel index.
- Minimum spacing for lossless capture per channel is 2 clk between qualified edges, with the FIFO not full.
- o_evt_valid drops the cycle after the last pop.

## Test plan
- Reset, CLK_PERIOD_NS=25: after 4 cycles, snapshot → ov_timestamp_reg=75. Then i_cnt_set with 0xFFFF_FFFF_FFFF_FFF0 → counter wraps to 0x9 two cycles later.
- Ch0 mode 01 rising pulse, ready=1 → one event {ch=0, edge=1, ts=cnt at detect}. o_evt_valid is asserted 2 clk after detect, then drops. The falling edge produces no event.
- All 4 channels in mode 11, same-cycle rising edge → 4 FIFO entries ch0..ch3 with identical ts, written on consecutive cycles. Level reaches 4.
- i_evt_ready=0 with 8 events queued: 9th and 10th edges on ch1 → the 9th is held pending, the 10th is dropped, and o_overflow=1. Then ready=1 → 9 events drained in order.
- i_overflow_clr concurrent with a new drop → o_overflow stays 1. Clear alone → 0.
- iv_trig held high through reset → no event after release. Reset asserted mid-queue → FIFO empty, pending cleared, all outputs 0 on the next cycle.

Source files
------------

// File: rtl/timestamp_mc.sv
// timestamp_mc: multi-channel edge timestamp unit.
//   A free-running nanosecond counter (step CLK_PERIOD_NS, presettable) is
//   used to time-tag edges on CH_NUM asynchronous trigger inputs. Each input
//   has its own edge selection. Tagged events pass through a per-channel
//   pending register and a fixed-priority arbiter into a FWFT FIFO with a
//   registered head, which feeds a ready/valid consumer.
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   iv_trig               asynchronous trigger inputs, one per channel
//   iv_edge_mode          2 bits per channel: 00 off, 01 rise, 10 fall, 11 both
//   i_cnt_set/iv_cnt_set_val   counter preset
//   i_timestamp_load/ov_timestamp_reg  register-side counter snapshot
//   ov_evt_ts/ov_evt_ch/o_evt_edge/o_evt_valid/i_evt_ready  event stream
//   ov_fifo_level         FIFO occupancy (including the head entry)
//   o_overflow/i_overflow_clr  sticky event-loss flag and its clear
module timestamp_mc #(
  parameter int unsigned CLK_PERIOD_NS = 25,
  parameter int unsigned LONG_REG_WD   = 64,
  parameter int unsigned CH_NUM        = 4,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CH_NUM-1:0]             iv_trig,
  input  logic [2*CH_NUM-1:0]           iv_edge_mode,
  input  logic                          i_cnt_set,
  input  logic [LONG_REG_WD-1:0]        iv_cnt_set_val,
  input  logic                          i_timestamp_load,
  output logic [LONG_REG_WD-1:0]        ov_timestamp_reg,
  output logic [LONG_REG_WD-1:0]        ov_evt_ts,
  output logic [2:0]                    ov_evt_ch,
  output logic                          o_evt_edge,
  output logic                          o_evt_valid,
  input  logic                          i_evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   ov_fifo_level,
  output logic                          o_overflow,
  input  logic                          i_overflow_clr
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned LW    = AW + 1;
  localparam int unsigned CHN   = SYNC_STAGES + 1;
  localparam int unsigned MW    = $clog2(CHN + 1);
  localparam int unsigned ENT_W = LONG_REG_WD + 4;  // {ts, ch[2:0], edge}

  logic [LONG_REG_WD-1:0]              cnt_q, cnt_d;
  logic [LONG_REG_WD-1:0]              ts_reg_q;
  logic [CH_NUM-1:0][CHN-1:0]          sync_q;
  logic [MW-1:0]                       mask_q;
  logic                                det_en_s;
  logic [CH_NUM-1:0]                   qual_s, rise_s, cap_s, drop_s, grant_s;
  logic [CH_NUM-1:0]                   pend_q, pend_edge_q;
  logic [CH_NUM-1:0][LONG_REG_WD-1:0]  pend_ts_q;
  logic                                grant_vld_s, found_s, fifo_full_s;
  logic [ENT_W-1:0]                    wr_ent_s;
  logic [FIFO_DEPTH-1:0][ENT_W-1:0]    mem_q;
  logic [AW-1:0]                       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ENT_W-1:0]                    head_q, head_d;
  logic                                head_vld_q, head_vld_d;
  logic [LW-1:0]                       level_q, level_d, body_cnt_s;
  logic                                pop_s, body_we_s;
  logic                                ovf_q, ovf_d;

  // Counter next value: preset wins over increment; increment wraps silently.
  always_comb begin
    if (i_cnt_set) begin
      cnt_d = iv_cnt_set_val;
    end else begin
      cnt_d = cnt_q + LONG_REG_WD'(CLK_PERIOD_NS);
    end
  end

  // Counter, snapshot, synchroniser chains and post-reset detection mask.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q    <= '0;
      ts_reg_q <= '0;
      sync_q   <= '0;
      mask_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (i_timestamp_load) begin
        ts_reg_q <= cnt_q;
      end
      for (int k = 0; k < CH_NUM; k++) begin
        sync_q[k] <= {sync_q[k][CHN-2:0], iv_trig[k]};
      end
      // Mask counts the first CHN cycles after reset so that a level already
      // high while the chains refill from 0 is not seen as a rising edge.
      if (mask_q != MW'(CHN)) begin
        mask_q <= mask_q + MW'(1);
      end
    end
  end

  assign det_en_s    = (mask_q == MW'(CHN));
  assign fifo_full_s = (level_q == LW'(FIFO_DEPTH));

  // Edge detection, capture/drop decision and lowest-index-first arbitration.
  always_comb begin
    grant_s  = '0;
    found_s  = 1'b0;
    wr_ent_s = '0;
    for (int k = 0; k < CH_NUM; k++) begin
      if (!found_s && pend_q[k] && !fifo_full_s) begin
        grant_s[k] = 1'b1;
        found_s    = 1'b1;
        wr_ent_s   = {pend_ts_q[k], 3'(k), pend_edge_q[k]};
      end else begin
        grant_s[k] = 1'b0;
      end
    end
    for (int k = 0; k < CH_NUM; k++) begin
      // Oldest synchroniser bit at CHN-1; {old,new} = 01 is rise, 10 is fall.
      rise_s[k] = ~sync_q[k][CHN-1] & sync_q[k][CHN-2];
      qual_s[k] = det_en_s &
                  ((rise_s[k] & iv_edge_mode[2*k]) |
                   ((sync_q[k][CHN-1] & ~sync_q[k][CHN-2]) & iv_edge_mode[2*k+1]));
      // A pending entry being granted this cycle frees the slot for a new one.
      cap_s[k]  = qual_s[k] & (~pend_q[k] | grant_s[k]);
      drop_s[k] = qual_s[k] & pend_q[k] & ~grant_s[k];
    end
  end

  assign grant_vld_s = |grant_s;

  // Per-channel pending registers: capture takes the pre-update counter value.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q      <= '0;
      pend_edge_q <= '0;
      pend_ts_q   <= '0;
    end else begin
      for (int k = 0; k < CH_NUM; k++) begin
        if (cap_s[k]) begin
          pend_q[k]      <= 1'b1;
          pend_ts_q[k]   <= cnt_q;
          pend_edge_q[k] <= rise_s[k];
        end else if (grant_s[k]) begin
          pend_q[k] <= 1'b0;
        end
      end
    end
  end

  assign pop_s      = head_vld_q & i_evt_ready;
  assign body_cnt_s = level_q - LW'(head_vld_q);

  // FIFO control: the head register is refilled from the body, or directly
  // from the write port when the body is empty (fall-through).
  always_comb begin
    head_d     = head_q;
    head_vld_d = head_vld_q;
    rd_ptr_d   = rd_ptr_q;
    body_we_s  = 1'b0;
    if (!head_vld_q || pop_s) begin
      if (body_cnt_s != LW'(0)) begin
        head_d     = mem_q[rd_ptr_q];
        head_vld_d = 1'b1;
        rd_ptr_d   = rd_ptr_q + AW'(1);
        body_we_s  = grant_vld_s;
      end else if (grant_vld_s) begin
        head_d     = wr_ent_s;
        head_vld_d = 1'b1;
      end else begin
        head_vld_d = 1'b0;
      end
    end else begin
      body_we_s = grant_vld_s;
    end
    if (body_we_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    case ({grant_vld_s, pop_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // A new loss in the same cycle wins over the clear request.
    if (|drop_s) begin
      ovf_d = 1'b1;
    end else if (i_overflow_clr) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // FIFO state, head register and overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q     <= '0;
      head_vld_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      head_q     <= head_d;
      head_vld_q <= head_vld_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
    end
  end

  // FIFO body storage; contents are don't-care while unoccupied.
  always_ff @(posedge clk) begin
    if (body_we_s) begin
      mem_q[wr_ptr_q] <= wr_ent_s;
    end
  end

  assign ov_timestamp_reg = ts_reg_q;
  assign ov_evt_ts        = head_q[ENT_W-1:4];
  assign ov_evt_ch        = head_q[3:1];
  assign o_evt_edge       = head_q[0];
  assign o_evt_valid      = head_vld_q;
  assign ov_fifo_level    = level_q;
  assign o_overflow       = ovf_q;

endmodule

// File: tb/tb_timestamp_mc.sv
// Directed self-checking bench for timestamp_mc (default parameters).
module tb_timestamp_mc;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  iv_trig;
  logic [7:0]  iv_edge_mode;
  logic        i_cnt_set;
  logic [63:0] iv_cnt_set_val;
  logic        i_timestamp_load;
  logic [63:0] ov_timestamp_reg;
  logic [63:0] ov_evt_ts;
  logic [2:0]  ov_evt_ch;
  logic        o_evt_edge;
  logic        o_evt_valid;
  logic        i_evt_ready;
  logic [3:0]  ov_fifo_level;
  logic        o_overflow;
  logic        i_overflow_clr;

  int n_pass  = 0;
  int n_total = 0;

  timestamp_mc dut (
    .clk(clk), .reset(reset), .iv_trig(iv_trig), .iv_edge_mode(iv_edge_mode),
    .i_cnt_set(i_cnt_set), .iv_cnt_set_val(iv_cnt_set_val),
    .i_timestamp_load(i_timestamp_load), .ov_timestamp_reg(ov_timestamp_reg),
    .ov_evt_ts(ov_evt_ts), .ov_evt_ch(ov_evt_ch), .o_evt_edge(o_evt_edge),
    .o_evt_valid(o_evt_valid), .i_evt_ready(i_evt_ready),
    .ov_fifo_level(ov_fifo_level), .o_overflow(o_overflow),
    .i_overflow_clr(i_overflow_clr)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_counter();
    reset = 1'b1; iv_trig = 4'h0; iv_edge_mode = 8'h00; i_cnt_set = 1'b0;
    iv_cnt_set_val = 64'd0; i_timestamp_load = 1'b0; i_evt_ready = 1'b0;
    i_overflow_clr = 1'b0;
    cyc(3);
    reset = 1'b0;
    n_total++;
    if ({ov_timestamp_reg, ov_evt_ts, ov_evt_ch, o_evt_edge, o_evt_valid, ov_fifo_level, o_overflow} !== 137'd0)
      $display("FAIL reset_outputs ts_reg=%0h ts=%0h ch=%0d edge=%0b vld=%0b lvl=%0d ovf=%0b expected all 0",
               ov_timestamp_reg, ov_evt_ts, ov_evt_ch, o_evt_edge, o_evt_valid, ov_fifo_level, o_overflow);
    else n_pass++;
    cyc(3);
    i_timestamp_load = 1'b1;
    cyc(1);
    i_timestamp_load = 1'b0;
    n_total++;
    if (ov_timestamp_reg !== 64'd75) $display("FAIL snapshot_75 got %0d expected 75", ov_timestamp_reg);
    else n_pass++;
    i_cnt_set = 1'b1; iv_cnt_set_val = 64'hFFFF_FFFF_FFFF_FFF0;
    cyc(1);
    i_cnt_set = 1'b0; i_timestamp_load = 1'b1;
    cyc(1);
    n_total++;
    if (ov_timestamp_reg !== 64'hFFFF_FFFF_FFFF_FFF0) $display("FAIL snapshot_preset got %0h expected fffffffffffffff0", ov_timestamp_reg);
    else n_pass++;
    cyc(1);
    i_timestamp_load = 1'b0;
    n_total++;
    if (ov_timestamp_reg !== 64'h9) $display("FAIL snapshot_wrap got %0h expected 9", ov_timestamp_reg);
    else n_pass++;
    cyc(1);
    n_total++;
    if (ov_timestamp_reg !== 64'h9) $display("FAIL snapshot_hold got %0h expected 9", ov_timestamp_reg);
    else n_pass++;
  endtask

  task automatic test_single_rise();
    logic bad;
    iv_edge_mode = 8'h01; i_evt_ready = 1'b1;
    iv_trig = 4'h1; i_cnt_set = 1'b1; iv_cnt_set_val = 64'd1000;
    cyc(1);
    i_cnt_set = 1'b0;
    cyc(2);
    n_total++;
    if (o_evt_valid !== 1'b0 || ov_fifo_level !== 4'd0)
      $display("FAIL rise_early vld=%0b lvl=%0d expected 0/0", o_evt_valid, ov_fifo_level);
    else n_pass++;
    cyc(1);
    n_total++;
    if ({o_evt_valid, ov_evt_ch, o_evt_edge, ov_evt_ts, ov_fifo_level} !== {1'b1, 3'd0, 1'b1, 64'd1025, 4'd1})
      $display("FAIL rise_event vld=%0b ch=%0d edge=%0b ts=%0d lvl=%0d expected 1/0/1/1025/1",
               o_evt_valid, ov_evt_ch, o_evt_edge, ov_evt_ts, ov_fifo_level);
    else n_pass++;
    cyc(1);
    n_total++;
    if (o_evt_valid !== 1'b0 || ov_fifo_level !== 4'd0)
      $display("FAIL rise_pop vld=%0b lvl=%0d expected 0/0", o_evt_valid, ov_fifo_level);
    else n_pass++;
    iv_trig = 4'h0;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      if (o_evt_valid !== 1'b0) bad = 1'b1;
    end
    n_total++;
    if (bad !== 1'b0) $display("FAIL fall_ignored event seen=%0b expected 0", bad);
    else n_pass++;
  endtask

  task automatic test_same_cycle();
    iv_edge_mode = 8'hFF; i_evt_ready = 1'b0;
    iv_trig = 4'hF; i_cnt_set = 1'b1; iv_cnt_set_val = 64'd2000;
    cyc(1);
    i_cnt_set = 1'b0;
    cyc(2);
    n_total++;
    if (ov_fifo_level !== 4'd0) $display("FAIL multi_lvl0 got %0d expected 0", ov_fifo_level);
    else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      cyc(1);
      n_total++;
      if (ov_fifo_level !== 4'(i)) $display("FAIL multi_lvl got %0d expected %0d", ov_fifo_level, i);
      else n_pass++;
    end
    i_evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if ({o_evt_valid, ov_evt_ch, o_evt_edge, ov_evt_ts} !== {1'b1, 3'(i), 1'b1, 64'd2025})
        $display("FAIL multi_head vld=%0b ch=%0d edge=%0b ts=%0d expected 1/%0d/1/2025",
                 o_evt_valid, ov_evt_ch, o_evt_edge, ov_evt_ts, i);
      else n_pass++;
      cyc(1);
    end
    n_total++;
    if (o_evt_valid !== 1'b0 || ov_fifo_level !== 4'd0)
      $display("FAIL multi_empty vld=%0b lvl=%0d expected 0/0", o_evt_valid, ov_fifo_level);
    else n_pass++;
    iv_edge_mode = 8'h00; iv_trig = 4'h0;
    cyc(6);
  endtask

  task automatic test_fifo_full();
    iv_edge_mode = 8'hFF; i_evt_ready = 1'b0;
    iv_trig = 4'hF; i_cnt_set = 1'b1; iv_cnt_set_val = 64'd3000;
    cyc(1);
    i_cnt_set = 1'b0;
    cyc(7);
    n_total++;
    if (ov_fifo_level !== 4'd4) $display("FAIL full_half got %0d expected 4", ov_fifo_level);
    else n_pass++;
    iv_trig = 4'h0; i_cnt_set = 1'b1; iv_cnt_set_val = 64'd4000;
    cyc(1);
    i_cnt_set = 1'b0;
    cyc(7);
    n_total++;
    if ({ov_fifo_level, o_evt_valid, o_overflow} !== {4'd8, 1'b1, 1'b0})
      $display("FAIL full_8 lvl=%0d vld=%0b ovf=%0b expected 8/1/0", ov_fifo_level, o_evt_valid, o_overflow);
    else n_pass++;
  endtask

  task automatic test_overflow();
    iv_trig = 4'h2; i_cnt_set = 1'b1; iv_cnt_set_val = 64'd5000;
    cyc(1);
    i_cnt_set = 1'b0;
    cyc(1);
    iv_trig = 4'h0;
    cyc(2);
    n_total++;
    if (o_overflow !== 1'b0 || ov_fifo_level !== 4'd8)
      $display("FAIL ovf_held ovf=%0b lvl=%0d expected 0/8", o_overflow, ov_fifo_level);
    else n_pass++;
    cyc(3);
    n_total++;
    if (o_overflow !== 1'b1) $display("FAIL ovf_drop got %0b expected 1", o_overflow);
    else n_pass++;
    iv_trig = 4'h2;
    cyc(2);
    i_overflow_clr = 1'b1;
    cyc(1);
    i_overflow_clr = 1'b0;
    n_total++;
    if (o_overflow !== 1'b1) $display("FAIL ovf_set_priority got %0b expected 1", o_overflow);
    else n_pass++;
    cyc(2);
    i_overflow_clr = 1'b1;
    cyc(1);
    i_overflow_clr = 1'b0;
    n_total++;
    if (o_overflow !== 1'b0 || ov_fifo_level !== 4'd8)
      $display("FAIL ovf_clear ovf=%0b lvl=%0d expected 0/8", o_overflow, ov_fifo_level);
    else n_pass++;
  endtask

  task automatic test_drain();
    logic [2:0]  exp_ch [9];
    logic        exp_edge [9];
    logic [63:0] exp_ts [9];
    for (int i = 0; i < 4; i++) begin
      exp_ch[i] = 3'(i);   exp_edge[i] = 1'b1;   exp_ts[i] = 64'd3025;
      exp_ch[i+4] = 3'(i); exp_edge[i+4] = 1'b0; exp_ts[i+4] = 64'd4025;
    end
    exp_ch[8] = 3'd1; exp_edge[8] = 1'b1; exp_ts[8] = 64'd5025;
    i_evt_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      n_total++;
      if ({o_evt_valid, ov_evt_ch, o_evt_edge, ov_evt_ts} !== {1'b1, exp_ch[i], exp_edge[i], exp_ts[i]})
        $display("FAIL drain_%0d vld=%0b ch=%0d edge=%0b ts=%0d expected 1/%0d/%0b/%0d",
                 i, o_evt_valid, ov_evt_ch, o_evt_edge, ov_evt_ts, exp_ch[i], exp_edge[i], exp_ts[i]);
      else n_pass++;
      cyc(1);
    end
    n_total++;
    if (o_evt_valid !== 1'b0 || ov_fifo_level !== 4'd0)
      $display("FAIL drain_empty vld=%0b lvl=%0d expected 0/0", o_evt_valid, ov_fifo_level);
    else n_pass++;
    iv_edge_mode = 8'h00; iv_trig = 4'h0;
    cyc(6);
  endtask

  task automatic test_reset_behaviour();
    iv_trig = 4'hF; iv_edge_mode = 8'hFF; i_evt_ready = 1'b0;
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    n_total++;
    if ({ov_timestamp_reg, o_evt_valid, ov_fifo_level, o_overflow} !== 70'd0)
      $display("FAIL rst_clear ts_reg=%0h vld=%0b lvl=%0d ovf=%0b expected all 0",
               ov_timestamp_reg, o_evt_valid, ov_fifo_level, o_overflow);
    else n_pass++;
    cyc(10);
    n_total++;
    if (o_evt_valid !== 1'b0 || ov_fifo_level !== 4'd0)
      $display("FAIL rst_high_level vld=%0b lvl=%0d expected 0/0", o_evt_valid, ov_fifo_level);
    else n_pass++;
    iv_trig = 4'h0;
    cyc(4);
    n_total++;
    if (ov_fifo_level !== 4'd1) $display("FAIL rst_queue_formed got %0d expected 1", ov_fifo_level);
    else n_pass++;
    reset = 1'b1;
    cyc(1);
    n_total++;
    if ({ov_timestamp_reg, ov_evt_ts, ov_evt_ch, o_evt_edge, o_evt_valid, ov_fifo_level, o_overflow} !== 137'd0)
      $display("FAIL rst_mid_queue ts=%0h ch=%0d edge=%0b vld=%0b lvl=%0d ovf=%0b expected all 0",
               ov_evt_ts, ov_evt_ch, o_evt_edge, o_evt_valid, ov_fifo_level, o_overflow);
    else n_pass++;
    reset = 1'b0;
    cyc(10);
    n_total++;
    if (o_evt_valid !== 1'b0 || ov_fifo_level !== 4'd0)
      $display("FAIL rst_pending_cleared vld=%0b lvl=%0d expected 0/0", o_evt_valid, ov_fifo_level);
    else n_pass++;
  endtask

  initial begin
    test_reset_counter();
    test_single_rise();
    test_same_cycle();
    test_fifo_full();
    test_overflow();
    test_drain();
    test_reset_behaviour();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
